// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder. A request in IDLE captures both operands and the
// initial carry. The block then resolves one result bit per clock, LSB first,
// over WIDTH ADD cycles. It presents {carry, sum} for a single DONE cycle and
// returns to IDLE.
//
// Ports
//   clock     : single clock, rising-edge active
//   reset     : synchronous active-high reset
//   start     : begin an addition (honoured in IDLE only)
//   input_a   : operand A, captured on the accepting edge
//   input_b   : operand B, captured on the accepting edge
//   carry_in  : initial carry, captured on the accepting edge
//   busy      : high while the ADD phase is running
//   done      : one-cycle pulse, sum/carry valid
//   sum       : registered result, held between completions
//   carry     : registered carry-out of bit WIDTH-1, held between completions
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand shift registers: bit 0 always holds the bit being processed.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             c_reg;
  // Result bits enter at the MSB, so after WIDTH shifts the LSB lands at bit 0.
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       ha0;
  logic [1:0]       ha1;
  logic             bit_s;
  logic             c_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] r_nxt;

  // Half adder: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full-add of the current bit built from two chained half-add stages; the
  // second stage consumes the carry registered from the previous bit.
  always_comb begin
    ha0      = half_add(a_sh[0], b_sh[0]);
    ha1      = half_add(ha0[0], c_reg);
    bit_s    = ha1[0];
    c_nxt    = ha0[1] | ha1[1];
    last_bit = (cnt == LAST_BIT);
    r_nxt    = {bit_s, r_sh[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ADD;
      S_ADD:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_ADD);
  assign done = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: capture on accept, shift during ADD, publish on entry to DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      c_reg <= 1'b0;
      r_sh  <= '0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= input_a;
            b_sh  <= input_b;
            c_reg <= carry_in;
            cnt   <= '0;
          end
        end
        S_ADD: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          c_reg <= c_nxt;
          r_sh  <= r_nxt;
          // The counter parks on the last index; a new accept clears it.
          if (last_bit) begin
            sum   <= r_nxt;
            carry <= c_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] input_a;
  logic [7:0] input_b;
  logic       carry_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;

  int total = 0;
  int bad   = 0;

  logic [7:0] prev_sum;
  logic       prev_carry;

  serial_adder #(.WIDTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .input_a  (input_a),
    .input_b  (input_b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One addition from IDLE: accept, scramble ports during ADD, check result.
  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [8:0] exp, input logic mid_start);
    int n;
    start    = 1'b1;
    input_a  = a;
    input_b  = b;
    carry_in = cin;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      check("busy_in_add", 32'(busy), 32'd1);
      check("sum_hold", 32'(sum), 32'(prev_sum));
      check("carry_hold", 32'(carry), 32'(prev_carry));
      input_a  = 8'($urandom);
      input_b  = 8'($urandom);
      carry_in = 1'($urandom);
      if (mid_start && n == 3) begin
        start   = 1'b1;
        input_a = 8'hAA;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    check("latency", 32'(n), 32'd8);
    check("sum", 32'(sum), 32'(exp[7:0]));
    check("carry", 32'(carry), 32'(exp[8]));
    check("busy_in_done", 32'(busy), 32'd0);
    prev_sum   = exp[7:0];
    prev_carry = exp[8];
    start = 1'b0;
    @(negedge clock);
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("sum_after", 32'(sum), 32'(prev_sum));
  endtask

  logic [7:0] tab_a [3];
  logic [7:0] tab_b [3];
  logic       tab_c [3];
  logic [8:0] tab_e [3];

  initial begin
    int dones;
    int t;
    reset    = 1'b1;
    start    = 1'b1;
    input_a  = 8'h5A;
    input_b  = 8'hC3;
    carry_in = 1'b1;
    prev_sum   = 8'h00;
    prev_carry = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("idle_no_start", 32'(busy), 32'd0);

    run_add(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    run_add(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0);
    run_add(8'h12, 8'h34, 1'b0, 9'h046, 1'b1);
    @(negedge clock);
    check("mid_start_ignored", 32'(busy), 32'd0);

    // Reset in the middle of ADD discards the addition.
    start    = 1'b1;
    input_a  = 8'h0F;
    input_b  = 8'h01;
    carry_in = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);
    check("sum_after_rst", 32'(sum), 32'd0);

    // Continuous start straight out of reset: accepts every 10 cycles.
    tab_a[0] = 8'h01; tab_b[0] = 8'h02; tab_c[0] = 1'b0; tab_e[0] = 9'h003;
    tab_a[1] = 8'h80; tab_b[1] = 8'h80; tab_c[1] = 1'b1; tab_e[1] = 9'h101;
    tab_a[2] = 8'h5A; tab_b[2] = 8'hA5; tab_c[2] = 1'b1; tab_e[2] = 9'h100;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b1;
    t = 0;
    for (int j = 0; j < 30; j++) begin
      if (j % 10 == 0) begin
        input_a  = tab_a[j / 10];
        input_b  = tab_b[j / 10];
        carry_in = tab_c[j / 10];
      end else begin
        input_a  = 8'($urandom);
        input_b  = 8'($urandom);
        carry_in = 1'($urandom);
      end
      @(negedge clock);
      if (done === 1'b1) begin
        check("cont_done_cycle", 32'(j), 32'(10 * t + 8));
        if (t < 3) begin
          check("cont_sum", 32'(sum), 32'(tab_e[t][7:0]));
          check("cont_carry", 32'(carry), 32'(tab_e[t][8]));
        end
        t++;
      end
    end
    start = 1'b0;
    check("cont_done_count", 32'(t), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous active-high reset, sampled on rising edge of clock.
REQ-004 Port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port input_a  input  WIDTH  operand A; captured on the accepting edge only.
REQ-006 Port input_b  input  WIDTH  operand B; captured on the accepting edge only.
REQ-007 Port carry_in  input  1  initial carry; captured on the accepting edge only.
REQ-008 Port busy  output  1  high while an addition is in progress.
REQ-009 Port done  output  1  single-cycle pulse; result valid.
REQ-010 Port sum  output  WIDTH  registered result; held between completions.
REQ-011 Port carry  output  1  registered carry-out of bit WIDTH-1; held between completions.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-013 In IDLE with start=1 on a rising edge, the block SHALL capture input_a, input_b and carry_in, clear the bit counter to 0, and enter ADD.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-015 In ADD, each edge SHALL produce one result bit, LSB first: bit = a[i] ^ b[i] ^ c; c_next = (a[i] & b[i]) | (c & (a[i] ^ b[i])). Internally this is two chained half-add stages on registered carry.
REQ-016 The bit counter SHALL increment once per ADD cycle. After the edge that processes bit WIDTH-1, the FSM SHALL enter DONE. There is no wrap of the counter into a second pass.
REQ-017 On entry to DONE, sum SHALL load the assembled WIDTH-bit result and carry SHALL load the final carry, both on the same edge.
REQ-018 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-019 done SHALL be 1 only in DONE. busy SHALL be 1 only in ADD.
REQ-020 Latency: for start accepted at edge k, done=1 in the cycle following edge k+WIDTH.
REQ-021 Throughput: at most one addition per WIDTH+2 cycles.
REQ-022 start SHALL be ignored in ADD and DONE.
REQ-023 Operand port changes after the accepting edge SHALL NOT affect the in-flight result.
REQ-024 sum and carry SHALL change only on entry to DONE or on reset. During ADD they SHALL hold the previous result.
REQ-025 Result arithmetic: {carry, sum} SHALL equal input_a + input_b + carry_in, computed modulo 2^(WIDTH+1).

Reset
REQ-026 While reset=1 at a rising edge, the FSM SHALL enter IDLE, and the following SHALL be cleared to 0: busy, done, sum, carry, bit counter, and internal operand/carry registers.
REQ-027 Reset SHALL take priority over start and over any in-progress ADD or DONE state. An interrupted addition SHALL be discarded with no done pulse.
REQ-028 A start asserted in the first cycle after reset deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 Accept a=0x0F, b=0x01, cin=0 -> busy high for 8 cycles; done pulse 1 cycle; sum=0x10, carry=0.
REQ-030 Accept a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1.
REQ-031 Accept a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1. During the operation, sum/carry SHALL hold the prior result until done.
REQ-032 Start a=0x12, b=0x34, then pulse start with a=0xAA mid-ADD and change operand ports -> result sum=0x46, carry=0; second start ignored.
REQ-033 Assert reset at ADD cycle 4 -> next cycle busy=0, done=0, sum=0x00, carry=0; no done pulse afterward.
REQ-034 Hold start=1 continuously -> done pulses every 10 cycles; each result reflects operands present on the accepting edge in IDLE.
